// File: rtl/ex_muldiv.sv
// Iterative RV64M multiply/divide unit for the EX stage.
// Radix-2 shift-add multiplier and restoring divider working on operand magnitudes.
// The sign fix-up is applied when the result is written. Divide-by-zero and signed
// overflow finish in a single cycle. While an op is in flight, stall_req holds the
// pipeline, so the EX operands stay stable until done.
module ex_muldiv #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN + 1);
  localparam int unsigned PW = 2 * XLEN;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            word_q, word_d;
  logic            neg_q, neg_d;          // negate product / quotient
  logic            neg_rem_q, neg_rem_d;  // negate remainder (dividend sign)
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] result_q, result_d;

  // Operand decode from the EX inputs
  logic            eff_word, a_signed, b_signed, sign_a, sign_b;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, min_neg, special_res;

  // Datapath step values
  logic [PW-1:0]   mul_add, prod, prod_s;
  logic [XLEN:0]   div_shift, div_diff;
  logic            div_ge;
  logic [XLEN-1:0] div_quo, div_rem, quo_s, rem_s;

  // Word results always carry bit 31 into the upper half, unsigned forms included.
  function automatic logic [XLEN-1:0] fix_word(input logic w, input logic [XLEN-1:0] v);
    return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  // Decode signedness and word form, form magnitudes, and detect single-cycle special cases
  always_comb begin
    // Word is honoured only for the ops that have a *W form.
    eff_word = word & ((op == 3'd0) | op[2]);
    a_signed = (op == 3'd1) | (op == 3'd2) | (op == 3'd4) | (op == 3'd6);
    b_signed = (op == 3'd1) | (op == 3'd4) | (op == 3'd6);
    a_ext    = src1;
    b_ext    = src2;
    if (eff_word) begin
      a_ext = {{(XLEN-32){a_signed & src1[31]}}, src1[31:0]};
      b_ext = {{(XLEN-32){b_signed & src2[31]}}, src2[31:0]};
    end
    sign_a   = a_signed & a_ext[XLEN-1];
    sign_b   = b_signed & b_ext[XLEN-1];
    mag_a    = sign_a ? -a_ext : a_ext;
    mag_b    = sign_b ? -b_ext : b_ext;
    min_neg  = eff_word ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = op[2] & (b_ext == '0);
    div_ovf  = op[2] & ~op[0] & (a_ext == min_neg) & (b_ext == '1);
    special_res = '0;
    if (div_zero) begin
      special_res = op[1] ? a_ext : '1;
    end else if (div_ovf) begin
      special_res = op[1] ? '0 : a_ext;
    end
    special_res = fix_word(eff_word, special_res);
  end

  // One multiplier step and one restoring-division step, plus sign fix-up of the final values
  always_comb begin
    mul_add   = mplier_q[0] ? mcand_q : '0;
    prod      = acc_q + mul_add;
    prod_s    = neg_q ? -prod : prod;
    div_shift = {rem_q, quo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, dvsr_q};
    div_ge    = ~div_diff[XLEN];
    div_rem   = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    div_quo   = {quo_q[XLEN-2:0], div_ge};
    quo_s     = neg_q ? -div_quo : div_quo;
    rem_s     = neg_rem_q ? -div_rem : div_rem;
  end

  // Next-state logic for the FSM and all datapath registers
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    word_d    = word_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    dvsr_d    = dvsr_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    result_d  = result_q;
    case (state_q)
      StIdle: begin
        if (start && !flush) begin
          op_d      = op;
          word_d    = eff_word;
          neg_d     = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          cnt_d     = eff_word ? CW'(32) : CW'(XLEN);
          if (div_zero || div_ovf) begin
            result_d = special_res;
            state_d  = StDone;
          end else if (!op[2]) begin
            acc_d    = '0;
            mcand_d  = {{XLEN{1'b0}}, mag_a};
            mplier_d = mag_b;
            state_d  = StMul;
          end else begin
            rem_d   = '0;
            dvsr_d  = mag_b;
            // Left-align a word dividend so the divider always consumes from the MSB.
            quo_d   = eff_word ? (mag_a << (XLEN - 32)) : mag_a;
            state_d = StDiv;
          end
        end
      end
      StMul: begin
        acc_d    = prod;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          result_d = fix_word(word_q, (op_q == 3'd0) ? prod_s[XLEN-1:0] : prod_s[PW-1:XLEN]);
          state_d  = StDone;
        end
      end
      StDiv: begin
        quo_d = div_quo;
        rem_d = div_rem;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          result_d = fix_word(word_q, op_q[1] ? rem_s : quo_s);
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // A killed op never updates result.
    if (flush) begin
      state_d  = StIdle;
      result_d = result_q;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      op_q      <= '0;
      word_q    <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      dvsr_q    <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      word_q    <= word_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      dvsr_q    <= dvsr_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      result_q  <= result_d;
    end
  end

  assign done      = (state_q == StDone) & ~flush;
  assign stall_req = start & ~done & ~flush;
  assign result    = result_q;

endmodule
